// File: rtl/copperv_pkg.sv
// Shared defaults for the copperv instruction fetch path.
package copperv_pkg;
   localparam int          BUS_WIDTH       = 32;
   localparam int          PC_WIDTH        = 32;
   localparam int          INST_WIDTH      = 32;
   localparam int          FIFO_DEPTH      = 4;
   localparam int          MAX_OUTSTANDING = 2;
   localparam logic [31:0] PC_INIT         = 32'h0000_0000;
   localparam logic [31:0] PC_INC          = 32'd4;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; shared by the fetch buffer and the load/store buffer.
module fetch_fifo #(
   parameter int width = 32,
   parameter int depth = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  logic [width-1:0]       din_i,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(depth):0] count_o,
   output logic [width-1:0]       dout_o
);
   localparam int AW = $clog2(depth);

   logic [width-1:0] mem_q [depth];
   logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   always_comb begin
      full_o  = (cnt_q == (AW+1)'(depth));
      empty_o = (cnt_q == '0);
      do_push = push_i & ~full_o & ~flush_i;
      do_pop  = pop_i & ~empty_o & ~flush_i;
      rd_d    = rd_q + AW'(do_pop);
      wr_d    = wr_q + AW'(do_push);
      cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (flush_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

   // Head reads as zero while empty so the consumer never sees stale storage.
   assign count_o = cnt_q;
   assign dout_o  = empty_o ? '0 : mem_q[rd_q];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: credit-limited address issue, prefetch FIFO,
// and redirect handling that discards responses belonging to the old stream.
module fetch_unit
   import copperv_pkg::*;
#(
   parameter int                  bus_width       = BUS_WIDTH,
   parameter int                  pc_width        = PC_WIDTH,
   parameter logic [pc_width-1:0] pc_init         = pc_width'(PC_INIT),
   parameter int                  inst_width      = INST_WIDTH,
   parameter int                  fifo_depth      = FIFO_DEPTH,
   parameter int                  max_outstanding = MAX_OUTSTANDING
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_enable,
   output logic                  i_raddr_valid,
   input  logic                  i_raddr_ready,
   output logic [pc_width-1:0]   i_raddr,
   input  logic                  i_rdata_valid,
   output logic                  i_rdata_ready,
   input  logic [bus_width-1:0]  i_rdata,
   input  logic                  redirect_valid,
   input  logic [pc_width-1:0]   redirect_pc,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [inst_width-1:0] inst,
   output logic [pc_width-1:0]   inst_pc
);
   localparam int OW = $clog2(max_outstanding + 1);
   localparam int CW = $clog2(fifo_depth) + 1;

   logic                raddr_valid_q, raddr_valid_d;
   logic [pc_width-1:0] raddr_q, raddr_d;
   logic                pend_drop_q, pend_drop_d;
   logic [pc_width-1:0] req_pc_q, req_pc_d;
   logic [pc_width-1:0] head_pc_q, head_pc_d;
   logic [OW-1:0]       outst_q, outst_d;
   logic [OW-1:0]       drop_q, drop_d;

   logic          accept, rsp, push, pop, issue;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_cnt, fcount_n;
   logic [OW-1:0] live_n;

   always_comb begin
      accept = raddr_valid_q & i_raddr_ready;
      rsp    = i_rdata_valid & (outst_q != '0);
      push   = rsp & ~redirect_valid & (drop_q == '0) & ~fifo_full;
      pop    = ~fifo_empty & inst_ready & ~redirect_valid;
   end

   // Credit is judged on next-cycle occupancy so a presented request always has FIFO room.
   always_comb begin
      outst_d     = outst_q + OW'(accept) - OW'(rsp);
      pend_drop_d = pend_drop_q & ~accept;
      drop_d      = drop_q + OW'(accept & pend_drop_q) - OW'(rsp & (drop_q != '0));
      fcount_n    = fifo_cnt + CW'(push) - CW'(pop);
      if (redirect_valid) begin
         drop_d      = outst_d;
         pend_drop_d = raddr_valid_q & ~accept;
         fcount_n    = '0;
      end
      live_n = outst_d - drop_d;
      issue  = fetch_enable & ~redirect_valid & (~raddr_valid_q | accept)
             & (int'(outst_d) < max_outstanding)
             & ((int'(live_n) + int'(fcount_n)) < fifo_depth);
      raddr_valid_d = issue | (raddr_valid_q & ~accept);
      raddr_d       = issue ? req_pc_q : raddr_q;
      req_pc_d      = req_pc_q;
      head_pc_d     = head_pc_q;
      if (redirect_valid) begin
         req_pc_d  = redirect_pc;
         head_pc_d = redirect_pc;
      end else begin
         if (issue) req_pc_d = req_pc_q + pc_width'(PC_INC);
         if (pop)   head_pc_d = head_pc_q + pc_width'(PC_INC);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         raddr_valid_q <= 1'b0;
         raddr_q       <= pc_init;
         pend_drop_q   <= 1'b0;
         req_pc_q      <= pc_init;
         head_pc_q     <= pc_init;
         outst_q       <= '0;
         drop_q        <= '0;
      end else begin
         raddr_valid_q <= raddr_valid_d;
         raddr_q       <= raddr_d;
         pend_drop_q   <= pend_drop_d;
         req_pc_q      <= req_pc_d;
         head_pc_q     <= head_pc_d;
         outst_q       <= outst_d;
         drop_q        <= drop_d;
      end
   end

   fetch_fifo #(
      .width (inst_width),
      .depth (fifo_depth)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .din_i   (i_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt),
      .dout_o  (inst)
   );

   assign i_raddr_valid = raddr_valid_q;
   assign i_raddr       = raddr_q;
   assign i_rdata_ready = 1'b1;
   assign inst_valid    = ~fifo_empty;
   assign inst_pc       = head_pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: bus responder, stream-level scoreboard, literal pins.
module tb_fetch_unit;
   logic        clk = 1'b0, rst = 1'b1, fetch_enable = 1'b0;
   logic        i_raddr_valid, i_raddr_ready = 1'b0;
   logic [31:0] i_raddr;
   logic        i_rdata_valid = 1'b0, i_rdata_ready;
   logic [31:0] i_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid, inst_ready = 1'b0;
   logic [31:0] inst, inst_pc;

   int nvec = 0, nfail = 0;
   bit rsp_en = 1'b1;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .rst(rst), .fetch_enable(fetch_enable),
      .i_raddr_valid(i_raddr_valid), .i_raddr_ready(i_raddr_ready), .i_raddr(i_raddr),
      .i_rdata_valid(i_rdata_valid), .i_rdata_ready(i_rdata_ready), .i_rdata(i_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
   );

   typedef struct { logic [31:0] addr; bit stale; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

   req_t        infl[$];
   ent_t        mq[$];
   ent_t        pop_log[$];
   logic [31:0] acc_log[$];
   logic [31:0] bus_q[$];
   logic [31:0] exp_req_pc, pend_addr, prev_addr;
   bit          pend_stale, prev_pend;
   int          cyc, first_acc_cyc, first_iv_cyc;

   function automatic logic [31:0] memf(logic [31:0] a);
      return 32'h5EED_0000 ^ a;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: follows the instruction stream the specification implies.
   always @(negedge clk) begin
      bit acc, rsp, pop, rd;
      req_t r;
      int live;
      if (rst) begin
         infl.delete(); mq.delete(); bus_q.delete();
         exp_req_pc = 32'h0; pend_stale = 0; prev_pend = 0; prev_addr = '0;
         cyc = 0; first_acc_cyc = -1; first_iv_cyc = -1;
      end else begin
         cyc++;
         acc = i_raddr_valid && i_raddr_ready;
         rsp = i_rdata_valid;
         pop = inst_valid && inst_ready;
         rd  = redirect_valid;
         chk("inst_valid", inst_valid, mq.size() > 0);
         if (inst_valid && mq.size() > 0) begin
            chk("inst_pc", inst_pc, mq[0].pc);
            chk("inst", inst, mq[0].data);
            if (first_iv_cyc < 0) first_iv_cyc = cyc;
         end
         if (prev_pend) begin
            chk("raddr_valid_hold", i_raddr_valid, 1);
            chk("raddr_hold", i_raddr, prev_addr);
         end
         if (rsp) begin
            chk("rsp_has_request", infl.size() > 0, 1);
            if (infl.size() > 0) r = infl.pop_front();
         end
         if (pop && !rd) pop_log.push_back(mq.pop_front());
         if (rsp && !r.stale && !rd) mq.push_back('{r.addr, memf(r.addr)});
         if (acc) begin
            if (pend_stale) begin
               chk("stale_addr", i_raddr, pend_addr);
               infl.push_back('{i_raddr, 1'b1});
               pend_stale = 0;
            end else begin
               chk("raddr_seq", i_raddr, exp_req_pc);
               infl.push_back('{i_raddr, 1'b0});
               exp_req_pc += 32'd4;
            end
            acc_log.push_back(i_raddr);
            bus_q.push_back(i_raddr);
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
         end
         if (rd) begin
            mq.delete();
            foreach (infl[i]) infl[i].stale = 1'b1;
            if (i_raddr_valid && !acc) begin
               pend_stale = 1;
               pend_addr  = i_raddr;
            end
            exp_req_pc = redirect_pc;
         end
         live = 0;
         foreach (infl[i]) if (!infl[i].stale) live++;
         chk("outstanding_le_max", infl.size() <= 2, 1);
         chk("credit_le_depth", (live + mq.size()) <= 4, 1);
         prev_pend = i_raddr_valid && !i_raddr_ready;
         prev_addr = i_raddr;
      end
   end

   task automatic step(int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (rsp_en && !rst && bus_q.size() > 0) begin
            i_rdata_valid = 1'b1;
            i_rdata       = memf(bus_q.pop_front());
         end else begin
            i_rdata_valid = 1'b0;
         end
      end
   endtask

   task automatic redirect(logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      step(1);
      redirect_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(string tag);
      chk({tag, "_raddr_valid"}, i_raddr_valid, 0);
      chk({tag, "_raddr"}, i_raddr, 32'h0);
      chk({tag, "_inst_valid"}, inst_valid, 0);
      chk({tag, "_inst"}, inst, 32'h0);
      chk({tag, "_inst_pc"}, inst_pc, 32'h0);
      chk({tag, "_rdata_ready"}, i_rdata_ready, 1);
   endtask

   initial begin
      step(2);
      chk_reset_outputs("reset");
      rst = 1'b0;
      acc_log.delete(); pop_log.delete();

      // Sequential fetch
      fetch_enable = 1'b1; i_raddr_ready = 1'b1; inst_ready = 1'b1;
      step(12);
      chk("seq_addr0", acc_log[0], 32'h0);
      chk("seq_addr1", acc_log[1], 32'h4);
      chk("seq_addr2", acc_log[2], 32'h8);
      chk("seq_pc1", pop_log[1].pc, 32'h4);
      chk("seq_data1", pop_log[1].data, 32'h5EED_0004);
      chk("first_latency", first_iv_cyc - first_acc_cyc, 2);

      // Consumer backpressure
      inst_ready = 1'b0;
      step(10);
      chk("bp_held", mq.size(), 4);
      chk("bp_inst_valid", inst_valid, 1);
      inst_ready = 1'b1;
      step(12);

      // Redirect with two responses in flight
      rsp_en = 1'b0;
      step(4);
      chk("inflight_two", infl.size(), 2);
      acc_log.delete(); pop_log.delete();
      rsp_en = 1'b1;
      redirect(32'h100);
      chk("redir_flush", inst_valid, 0);
      step(10);
      chk("redir_first_addr", acc_log[0], 32'h100);
      chk("redir_pc0", pop_log[0].pc, 32'h100);
      chk("redir_data0", pop_log[0].data, 32'h5EED_0100);
      chk("redir_pc1", pop_log[1].pc, 32'h104);

      // Redirect while an address request is stalled
      fetch_enable = 1'b0;
      step(6);
      i_raddr_ready = 1'b0;
      redirect(32'h40);
      fetch_enable = 1'b1;
      step(3);
      chk("stall_valid", i_raddr_valid, 1);
      chk("stall_addr", i_raddr, 32'h40);
      acc_log.delete(); pop_log.delete();
      redirect(32'h200);
      step(2);
      chk("stall_hold", i_raddr, 32'h40);
      i_raddr_ready = 1'b1;
      step(10);
      chk("stall_acc0", acc_log[0], 32'h40);
      chk("stall_acc1", acc_log[1], 32'h200);
      chk("stall_pc0", pop_log[0].pc, 32'h200);
      chk("stall_data0", pop_log[0].data, 32'h5EED_0200);

      // Redirect coincident with a response and a pop
      chk("coincide_rsp", i_rdata_valid, 1);
      chk("coincide_pop", inst_valid && inst_ready, 1);
      pop_log.delete();
      redirect(32'h300);
      step(10);
      chk("coincide_pc0", pop_log[0].pc, 32'h300);
      chk("coincide_pc1", pop_log[1].pc, 32'h304);

      // Asynchronous reset between clock edges
      #2 rst = 1'b1;
      #1 chk_reset_outputs("async");
      step(2);
      rst = 1'b0;
      acc_log.delete(); pop_log.delete();
      step(8);
      chk("post_reset_addr0", acc_log[0], 32'h0);
      chk("post_reset_pc0", pop_log[0].pc, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
